// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg: baud codes, bit-period divisor and FSM states shared by
// the UART transmitter and receiver.            Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DIV_W = 20;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Each branch divides two constants, so synthesis folds it to a mux of literals.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [2:0] code);
    logic [DIV_W-1:0] div;
    case (code)
      BAUD_19200:  div = DIV_W'(clk_hz / 32'd19200);
      BAUD_38400:  div = DIV_W'(clk_hz / 32'd38400);
      BAUD_57600:  div = DIV_W'(clk_hz / 32'd57600);
      BAUD_115200: div = DIV_W'(clk_hz / 32'd115200);
      default:     div = DIV_W'(clk_hz / 32'd9600);
    endcase
    return div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_bit_timer: bit-period down-counter, one-cycle tick on expiry.
// Rev 1.0
// ------------------------------------------------------------------
module uart_bit_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // A load starts a period of i_div cycles: the tick lands on its last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div - W'(1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_byte_tx: 8N1 UART transmitter with one-byte holding register.
// Rev 1.0
// ------------------------------------------------------------------
module uart_byte_tx #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_TXD_Baud,
  input  logic [7:0] i_TXD_Data,
  input  logic       i_TXD_Valid,
  output logic       o_TXD_Ready,
  output logic       o_TXD_Tx,
  output logic       o_TXD_Busy,
  output logic       o_TXD_Done
);

  import uart_pkg::*;

  logic [1:0]       r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             r_ready;
  logic             r_tx;
  logic             r_busy;
  logic [DIV_W-1:0] r_div;

  logic [1:0]       w_state_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_bitcnt_nxt;
  logic [7:0]       w_hold_nxt;
  logic             w_hold_full_nxt;
  logic             w_tx_nxt;
  logic             w_load;
  logic             w_start;
  logic             w_take;
  logic             w_accept;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_now;
  logic [DIV_W-1:0] w_div_sel;

  assign w_accept  = i_TXD_Valid && r_ready;
  assign w_div_now = baud_div(CLK_HZ, i_TXD_Baud);
  // The baud code only matters on the edge that launches a start bit.
  assign w_div_sel = w_start ? w_div_now : r_div;

  uart_bit_timer #(
    .W (DIV_W)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state != ST_IDLE),
    .i_load (w_load),
    .i_div  (w_div_sel),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bitcnt_nxt    = r_bitcnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_tx_nxt        = r_tx;
    w_load          = 1'b0;
    w_start         = 1'b0;
    w_take          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_take      = 1'b1;
          w_start     = 1'b1;
          w_load      = 1'b1;
          w_shift_nxt = i_TXD_Data;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_load       = 1'b1;
          w_state_nxt  = ST_DATA;
          w_tx_nxt     = r_shift[0];
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bitcnt_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_load = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt     = r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Last stop cycle: chain straight into the next start bit when a byte waits.
        if (w_tick) begin
          if (r_hold_full) begin
            w_start         = 1'b1;
            w_load          = 1'b1;
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_state_nxt     = ST_START;
            w_tx_nxt        = 1'b0;
          end else if (w_accept) begin
            w_take      = 1'b1;
            w_start     = 1'b1;
            w_load      = 1'b1;
            w_shift_nxt = i_TXD_Data;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
    if (w_accept && !w_take) begin
      w_hold_nxt      = i_TXD_Data;
      w_hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= 8'h00;
      r_bitcnt    <= 3'd0;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_div       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_ready     <= !w_hold_full_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_div       <= w_div_sel;
    end
  end

  assign o_TXD_Ready = r_ready;
  assign o_TXD_Tx    = r_tx;
  assign o_TXD_Busy  = r_busy;
  assign o_TXD_Done  = (r_state == ST_STOP) && w_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_byte_tx: randomized scoreboard bench for uart_byte_tx.
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_byte_tx;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
    longint     acc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] i_TXD_Baud  = 3'd4;
  logic [7:0] i_TXD_Data  = 8'h00;
  logic       i_TXD_Valid = 1'b0;
  logic       o_TXD_Ready;
  logic       o_TXD_Tx;
  logic       o_TXD_Busy;
  logic       o_TXD_Done;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc_n   = 0;

  item_t  q[$];
  longint done_q[$];
  item_t  cur;
  bit     in_frame   = 0;
  bit     after_end  = 0;
  longint fc         = 0;
  longint prev_end   = 0;
  int     errs       = 0;
  longint first_bad  = -1;
  int     spurious   = 0;
  int     unexpected = 0;

  uart_byte_tx #(
    .CLK_HZ (50000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_TXD_Baud  (i_TXD_Baud),
    .i_TXD_Data  (i_TXD_Data),
    .i_TXD_Valid (i_TXD_Valid),
    .o_TXD_Ready (o_TXD_Ready),
    .o_TXD_Tx    (o_TXD_Tx),
    .o_TXD_Busy  (o_TXD_Busy),
    .o_TXD_Done  (o_TXD_Done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic int ref_div(input logic [2:0] code);
    int baud;
    case (code)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return 50000000 / baud;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: decodes the line cycle by cycle against the popped expectation.
  always @(negedge clk) begin
    int   k;
    logic lvl;
    if (rst) begin
      if (in_frame) begin
        check($sformatf("aborted frame 0x%02h prefix errors (first bad cycle %0d)", cur.data, first_bad), errs, 0);
        in_frame = 0;
      end
      q.delete();
      after_end = 0;
    end else begin
      if (!in_frame) begin
        if (o_TXD_Tx === 1'b0) begin
          if (q.size() == 0) begin
            unexpected++;
          end else begin
            cur       = q.pop_front();
            in_frame  = 1;
            fc        = 0;
            errs      = 0;
            first_bad = -1;
            check($sformatf("start cycle of 0x%02h", cur.data), cyc_n, cur.b2b ? prev_end + 1 : cur.acc);
            if (cur.b2b) check("ready after transfer", o_TXD_Ready, 1);
          end
        end else begin
          if (o_TXD_Done) spurious++;
          if (after_end) check("busy drop after last frame", o_TXD_Busy, 0);
        end
        after_end = 0;
      end
      if (in_frame) begin
        k   = int'(fc / cur.div);
        lvl = (k == 0) ? 1'b0 : (k <= 8) ? cur.data[k-1] : 1'b1;
        if (o_TXD_Tx !== lvl || o_TXD_Busy !== 1'b1 ||
            o_TXD_Done !== (fc == 10 * cur.div - 1)) begin
          errs++;
          if (first_bad < 0) first_bad = fc;
        end
        if (fc == 10 * cur.div - 1) begin
          check($sformatf("frame 0x%02h errors (first bad cycle %0d)", cur.data, first_bad), errs, 0);
          if (!cur.b2b) check("done latency", cyc_n - cur.acc + 1, 10 * cur.div);
          if (q.size() != 0) check("ready low in transfer cycle", o_TXD_Ready, 0);
          done_q.push_back(cyc_n);
          prev_end  = cyc_n;
          in_frame  = 0;
          after_end = 1;
        end
        fc++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input int div, input bit b2b);
    int     waited = 0;
    longint acc;
    @(negedge clk);
    i_TXD_Data  = d;
    i_TXD_Valid = 1'b1;
    while (!o_TXD_Ready && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    if (!o_TXD_Ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send 0x%02h: ready never rose, got timeout, expected acceptance", d);
      i_TXD_Valid = 1'b0;
      return;
    end
    acc = cyc_n + 1;
    @(posedge clk);
    q.push_back('{data: d, div: div, b2b: b2b, acc: acc});
    #1 i_TXD_Valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("tx high at reset", o_TXD_Tx, 1);
    check("busy low at reset", o_TXD_Busy, 0);
    check("done low at reset", o_TXD_Done, 0);
    check("ready low at reset", o_TXD_Ready, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("ready after reset release", o_TXD_Ready, 1);
  endtask

  task automatic wait_cyc(input longint t);
    while (cyc_n < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((q.size() != 0 || in_frame) && g < 60000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d frames pending, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          bad;
    longint      acc0;
    logic [7:0]  rb;

    // Reset state and first edge after release.
    repeat (3) @(negedge clk);
    check("tx during reset", o_TXD_Tx, 1);
    check("busy during reset", o_TXD_Busy, 0);
    check("done during reset", o_TXD_Done, 0);
    check("ready during reset", o_TXD_Ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("ready first edge after reset", o_TXD_Ready, 1);

    // Long idle with Valid low.
    bad = 0;
    repeat (20000) begin
      @(negedge clk);
      if (o_TXD_Tx !== 1'b1 || o_TXD_Busy !== 1'b0 || o_TXD_Ready !== 1'b1 || o_TXD_Done !== 1'b0) bad++;
    end
    check("idle cycles with wrong outputs", bad, 0);

    // 0xA5 at 115200.
    i_TXD_Baud = 3'd4;
    send(8'hA5, ref_div(3'd4), 0);
    wait_idle();

    // Back-to-back 0x00 then 0xFF through the holding register.
    send(8'h00, ref_div(3'd4), 0);
    send(8'hFF, ref_div(3'd4), 1);
    @(negedge clk);
    check("ready low while holding full", o_TXD_Ready, 0);
    wait_idle();
    check("done spacing b2b", done_q[done_q.size()-1] - done_q[done_q.size()-2], 4340);

    // Random bytes streamed back-to-back.
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      send(rb, ref_div(3'd4), i != 0);
    end
    wait_idle();

    // Baud change 4->0 mid-frame; the queued frame runs slow and is cut by reset.
    rb = 8'($urandom);
    send(rb, ref_div(3'd4), 0);
    acc0 = cyc_n;
    repeat (1000) @(negedge clk);
    i_TXD_Baud = 3'd0;
    send(8'h81, ref_div(3'd0), 1);
    wait_cyc(acc0 + 4340 + 2 * 5208 + 100);
    pulse_rst();

    // Baud code 7 falls back to 9600.
    i_TXD_Baud = 3'd7;
    send(8'h01, ref_div(3'd7), 0);
    acc0 = cyc_n;
    wait_cyc(acc0 + 2 * 5208 + 100);
    pulse_rst();

    // Reset during data bit 3 with a byte held, then a clean 0x3C.
    i_TXD_Baud = 3'd4;
    send(8'h5A, ref_div(3'd4), 0);
    acc0 = cyc_n;
    send(8'h99, ref_div(3'd4), 1);
    wait_cyc(acc0 + 4 * 434 + 200);
    pulse_rst();
    send(8'h3C, ref_div(3'd4), 0);
    wait_idle();
    repeat (100) @(negedge clk);

    check("unexpected start bits", unexpected, 0);
    check("spurious done pulses", spurious, 0);
    check("frames still expected", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
